// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle for rr_priority_arbiter.
// The master side drives the request vector; the slave side returns the grant.
interface rr_priority_arbiter_if #(
   parameter int N = 4
);
   localparam int IDX_W = $clog2(N);

   logic [N-1:0]     req;
   logic [N-1:0]     grant;
   logic             grant_valid;
   logic [IDX_W-1:0] grant_idx;

   modport master (output req, input grant, input grant_valid, input grant_idx);
   modport slave  (input req, output grant, output grant_valid, output grant_idx);
endinterface

// File: rtl/rr_priority_arbiter.sv
// N-way arbiter with fixed-priority or round-robin selection, grant hold-until-release
// and an optional hold timeout that forces the grant to move on.
module rr_priority_arbiter #(
   parameter int N           = 4,
   parameter int ROUND_ROBIN = 0,
   parameter int MAX_HOLD    = 0
) (
   input logic                  clk,
   input logic                  reset,
   rr_priority_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(N);
   localparam int CNT_W = 16;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   logic             w_holder_req;
   logic             w_timeout;
   logic             w_new_grant;
   logic [N-1:0]     w_others;
   logic [N-1:0]     w_arb_req;
   logic [IDX_W-1:0] w_win;

   // Fixed mode scans from bit 0; round-robin scans upward from ptr with wrap.
   function automatic logic [IDX_W-1:0] arbitrate(input logic [N-1:0]     r,
                                                   input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] win;
      logic             found;
      int               j;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (ROUND_ROBIN != 0) ? int'(ptr) + k : k;
         if (j >= N) j -= N;
         if (!found && r[j]) begin
            found = 1'b1;
            win   = IDX_W'(j);
         end
      end
      return win;
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
      return (int'(w) == N - 1) ? '0 : w + 1'b1;
   endfunction

   assign w_holder_req = bus.req[r_idx];
   assign w_others     = bus.req & ~(N'(1) << r_idx);
   assign w_timeout    = (MAX_HOLD != 0) && (r_cnt == CNT_W'(MAX_HOLD - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case leaves a variable unassigned and infers a latch.
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_new_grant = 1'b0;
      w_arb_req   = bus.req;
      w_win       = '0;

      unique case (r_state)
         IDLE: begin
            if (|bus.req) w_new_grant = 1'b1;
         end
         BUSY: begin
            if (!w_holder_req) begin
               if (|bus.req) begin
                  w_new_grant = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_idx_nxt   = '0;
                  w_cnt_nxt   = '0;
               end
            end else if (w_timeout) begin
               // A lone holder arbitrates over its own request and wins again.
               w_new_grant = 1'b1;
               if (|w_others) w_arb_req = w_others;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_new_grant) begin
         w_win       = arbitrate(w_arb_req, r_ptr);
         w_state_nxt = BUSY;
         w_idx_nxt   = w_win;
         w_cnt_nxt   = '0;
         w_ptr_nxt   = next_ptr(w_win);
      end
   end

   always_comb begin
      bus.grant       = '0;
      bus.grant_valid = (r_state == BUSY);
      bus.grant_idx   = '0;
      if (r_state == BUSY) begin
         bus.grant[r_idx] = 1'b1;
         bus.grant_idx    = r_idx;
      end
   end
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Self-checking bench: five arbiter configurations run side by side against a
// behavioural model of holder, held-cycle count and last winner.
module tb_rr_priority_arbiter;
   localparam int NI = 5;
   localparam int P_N  [NI] = '{4, 4, 4, 8, 8};
   localparam int P_RR [NI] = '{0, 1, 1, 0, 1};
   localparam int P_MH [NI] = '{0, 0, 3, 5, 4};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [7:0] req_v     [NI];
   logic [7:0] act_grant [NI];
   logic       act_valid [NI];
   logic [2:0] act_idx   [NI];

   int n_cmp = 0;
   int n_bad = 0;

   rr_priority_arbiter_if #(.N(4)) if0 ();
   rr_priority_arbiter_if #(.N(4)) if1 ();
   rr_priority_arbiter_if #(.N(4)) if2 ();
   rr_priority_arbiter_if #(.N(8)) if3 ();
   rr_priority_arbiter_if #(.N(8)) if4 ();

   rr_priority_arbiter #(.N(4), .ROUND_ROBIN(0), .MAX_HOLD(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
   rr_priority_arbiter #(.N(4), .ROUND_ROBIN(1), .MAX_HOLD(0)) u1 (.clk(clk), .reset(reset), .bus(if1));
   rr_priority_arbiter #(.N(4), .ROUND_ROBIN(1), .MAX_HOLD(3)) u2 (.clk(clk), .reset(reset), .bus(if2));
   rr_priority_arbiter #(.N(8), .ROUND_ROBIN(0), .MAX_HOLD(5)) u3 (.clk(clk), .reset(reset), .bus(if3));
   rr_priority_arbiter #(.N(8), .ROUND_ROBIN(1), .MAX_HOLD(4)) u4 (.clk(clk), .reset(reset), .bus(if4));

   assign if0.req = req_v[0][3:0];
   assign if1.req = req_v[1][3:0];
   assign if2.req = req_v[2][3:0];
   assign if3.req = req_v[3];
   assign if4.req = req_v[4];

   assign act_grant[0] = 8'(if0.grant);
   assign act_grant[1] = 8'(if1.grant);
   assign act_grant[2] = 8'(if2.grant);
   assign act_grant[3] = if3.grant;
   assign act_grant[4] = if4.grant;
   assign act_valid[0] = if0.grant_valid;
   assign act_valid[1] = if1.grant_valid;
   assign act_valid[2] = if2.grant_valid;
   assign act_valid[3] = if3.grant_valid;
   assign act_valid[4] = if4.grant_valid;
   assign act_idx[0]   = 3'(if0.grant_idx);
   assign act_idx[1]   = 3'(if1.grant_idx);
   assign act_idx[2]   = 3'(if2.grant_idx);
   assign act_idx[3]   = if3.grant_idx;
   assign act_idx[4]   = if4.grant_idx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Winner = set bit with the smallest priority distance; round-robin distance
   // is measured upward from the slot just above the last winner.
   function automatic int pick(input logic [7:0] r, input int n, input int rr, input int last);
      int start, best, best_d, d;
      start  = (last + 1) % n;
      best   = -1;
      best_d = n;
      for (int i = 0; i < n; i++) begin
         if (r[i]) begin
            d = (rr != 0) ? (i - start + n) % n : i;
            if (d < best_d) begin
               best_d = d;
               best   = i;
            end
         end
      end
      return best;
   endfunction

   int m_holder [NI];
   int m_held   [NI];
   int m_last   [NI];
   int wait_c   [NI][8];

   initial begin
      logic [7:0] r_s [NI];
      logic       rst_s;
      logic [7:0] r, masked;
      int         w;
      for (int k = 0; k < NI; k++) begin
         m_holder[k] = -1;
         m_held[k]   = 0;
         m_last[k]   = -1;
         for (int i = 0; i < 8; i++) wait_c[k][i] = 0;
      end
      forever begin
         @(posedge clk);
         rst_s = reset;
         for (int k = 0; k < NI; k++) begin
            r = req_v[k] & 8'((1 << P_N[k]) - 1);
            r_s[k] = r;
            w = -2;
            if (rst_s) begin
               m_holder[k] = -1;
               m_held[k]   = 0;
               m_last[k]   = -1;
            end else if (m_holder[k] < 0) begin
               if (r != 0) w = pick(r, P_N[k], P_RR[k], m_last[k]);
            end else if (!r[m_holder[k]]) begin
               if (r != 0) w = pick(r, P_N[k], P_RR[k], m_last[k]);
               else begin
                  m_holder[k] = -1;
                  m_held[k]   = 0;
               end
            end else if (P_MH[k] != 0 && m_held[k] == P_MH[k]) begin
               masked = r;
               masked[m_holder[k]] = 1'b0;
               w = (masked != 0) ? pick(masked, P_N[k], P_RR[k], m_last[k]) : m_holder[k];
            end else begin
               m_held[k]++;
            end
            if (w >= 0) begin
               m_holder[k] = w;
               m_held[k]   = 1;
               m_last[k]   = w;
            end
         end
         #1;
         for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d_grant", k), act_grant[k],
                  (m_holder[k] < 0) ? 32'd0 : (32'd1 << m_holder[k]));
            check($sformatf("u%0d_valid", k), act_valid[k], (m_holder[k] >= 0) ? 32'd1 : 32'd0);
            check($sformatf("u%0d_idx", k), act_idx[k],
                  (m_holder[k] < 0) ? 32'd0 : 32'(m_holder[k]));
            check($sformatf("u%0d_onehot", k), 32'($onehot0(act_grant[k])), 32'd1);
            if (P_RR[k] != 0 && P_MH[k] != 0) begin
               for (int i = 0; i < P_N[k]; i++) begin
                  if (rst_s || !r_s[k][i] || act_grant[k][i]) wait_c[k][i] = 0;
                  else begin
                     wait_c[k][i]++;
                     check($sformatf("u%0d_starve%0d", k, i),
                           32'(wait_c[k][i] <= P_N[k] * P_MH[k]), 32'd1);
                  end
               end
            end
         end
      end
   end

   initial begin
      int e;
      reset = 1'b1;
      for (int k = 0; k < NI; k++) req_v[k] = 8'h00;

      // Reset and idle.
      repeat (2) tick();
      reset = 1'b0;
      repeat (5) begin
         tick();
         check("idle_grant", act_grant[0], 32'd0);
         check("idle_valid", act_valid[0], 32'd0);
         check("idle_idx", act_idx[0], 32'd0);
      end

      // Fixed priority: hold, handover without a gap, then release to idle.
      req_v[0] = 8'b1010;
      tick();
      check("fp_first_grant", act_grant[0], 32'b0010);
      check("fp_first_idx", act_idx[0], 32'd1);
      repeat (4) begin
         tick();
         check("fp_hold_grant", act_grant[0], 32'b0010);
      end
      req_v[0] = 8'b1000;
      tick();
      check("fp_handover_grant", act_grant[0], 32'b1000);
      check("fp_handover_idx", act_idx[0], 32'd3);
      check("fp_handover_valid", act_valid[0], 32'd1);
      req_v[0] = 8'b0000;
      tick();
      check("fp_release_grant", act_grant[0], 32'd0);
      check("fp_release_valid", act_valid[0], 32'd0);

      // Round-robin rotation 0,1,2,3,0,... as each holder briefly drops its request.
      req_v[1] = 8'h0F;
      tick();
      e = 0;
      check("rr_grant", act_grant[1], 32'd1);
      for (int s = 1; s <= 7; s++) begin
         req_v[1] = 8'h0F & ~(8'd1 << e);
         tick();
         e = (e + 1) % 4;
         check("rr_grant", act_grant[1], 32'd1 << e);
         check("rr_idx", act_idx[1], 32'(e));
      end

      // Timeout: two steady requesters alternate every 3 cycles, then a lone one is re-granted.
      req_v[2] = 8'b0011;
      for (int t = 0; t < 12; t++) begin
         tick();
         check("to_alt_grant", act_grant[2], 32'd1 << ((t / 3) % 2));
      end
      req_v[2] = 8'b0001;
      repeat (8) begin
         tick();
         check("to_lone_grant", act_grant[2], 32'b0001);
         check("to_lone_valid", act_valid[2], 32'd1);
      end

      // Reset while bit 2 is held; afterwards the rotation restarts from 0.
      req_v[1] = 8'b0100;
      tick();
      check("rst_pre_grant", act_grant[1], 32'b0100);
      tick();
      check("rst_pre_grant", act_grant[1], 32'b0100);
      reset    = 1'b1;
      req_v[1] = 8'b1100;
      tick();
      check("rst_grant", act_grant[1], 32'd0);
      check("rst_valid", act_valid[1], 32'd0);
      check("rst_idx", act_idx[1], 32'd0);
      reset = 1'b0;
      tick();
      check("rst_after_grant", act_grant[1], 32'b0100);
      check("rst_after_idx", act_idx[1], 32'd2);
      for (int k = 0; k < NI; k++) req_v[k] = 8'h00;
      tick();

      // Random stress on all configurations; requests persist a few cycles on average.
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < P_N[k]; i++) begin
               if (req_v[k][i]) begin
                  if ($urandom_range(0, 5) == 0) req_v[k][i] = 1'b0;
               end else begin
                  if ($urandom_range(0, 4) == 0) req_v[k][i] = 1'b1;
               end
            end
         end
         reset = ($urandom_range(0, 1999) == 0);
         tick();
      end
      reset = 1'b0;
      for (int k = 0; k < NI; k++) req_v[k] = 8'h00;
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
Registered N-way arbiter and next-generation one-hot priority selector. Each cycle it picks one requester from a request vector and presents it as a one-hot grant plus a binary index. It adds a parametrised width, a selectable fixed-priority (LSB-first) or round-robin mode, grant hold-until-release, and an optional hold timeout. It sits in front of shared resources such as a bus port, FIFO write side or DMA channel.

Parameters:
N, 4, number of requesters; legal range 2..32.
ROUND_ROBIN, 0, 0 = fixed priority with bit 0 highest; 1 = rotating priority starting just above the last winner.
MAX_HOLD, 0, maximum consecutive cycles one grant may be held. 0 = unlimited; otherwise 1..65535.
IDX_W, $clog2(N), width of grant_idx. Localparam, not user-set.

Ports:
clk  input  1  single clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
req  input  N  request vector; bit i high = requester i wants the resource.
grant  output  N  registered one-hot grant, or all zeros.
grant_valid  output  1  high iff grant is non-zero.
grant_idx  output  IDX_W  binary index of the set grant bit; 0 when grant_valid is low.

Behaviour:
- Reset (reset sampled high at a clk edge):
  - grant=0, grant_valid=0, grant_idx=0.
  - Rotation pointer ptr=0, hold counter cnt=0, state=IDLE.
  - Reset overrides everything, including reset during a held grant. Outputs are zero in the cycle after the reset edge.
- State machine, two states:
  - IDLE: no grant. If req!=0, arbitrate and go to BUSY with the winner registered. Latency from req to grant is exactly 1 cycle. If req==0, stay in IDLE.
  - BUSY: holder h = grant_idx.
    - Release: req[h]==0 at the edge. Re-arbitrate over the current req in the same edge. If a winner exists, the grant changes to it the next cycle with no idle gap and the state stays BUSY. If req==0, grant goes to 0 and the state returns to IDLE.
    - Timeout: MAX_HOLD!=0, req[h]==1 and cnt==MAX_HOLD-1. Re-arbitrate with bit h masked out. If another requester wins, the grant moves to it. If h is the only requester, h is re-granted and cnt restarts at 0.
    - Otherwise: hold the grant and increment cnt. cnt saturates when MAX_HOLD==0.
- cnt resets to 0 on every new or re-issued grant. The first granted cycle counts as hold cycle 0, so a continuous holder keeps the grant for exactly MAX_HOLD cycles.
- Arbitration function:
  - Fixed priority: lowest-index set bit wins, with bit 0 highest priority.
  - Round-robin: search upward from ptr, wrapping N-1 to 0, and take the first set bit. On each new grant to requester w, ptr <= (w+1) mod N. ptr does not change while a grant is held.
  - A re-issued timeout grant to the same holder still updates ptr by the same rule.
- The grant is always one-hot or zero and never has multiple bits set.
- grant_idx and grant_valid are registered together with grant and are consistent in every cycle.
- req bits of non-holders may toggle freely while a grant is held; they have no effect until release or timeout.
- A requester that drops and re-raises req in the same cycle is not a release. Release requires req[h] to be sampled low.

Test Plan:
1. Reset and idle: N=4, hold reset for 2 cycles, then req=0 for 5 cycles -> grant=0, grant_valid=0, grant_idx=0 throughout.
2. Fixed priority, hold and handover: N=4, ROUND_ROBIN=0, req=4'b1010 at cycle 0 -> grant=4'b0010 and grant_idx=1 from cycle 1. Drop req[1] at cycle 5 -> grant=4'b1000, grant_idx=3 at cycle 6 with no zero gap. Drop all req -> grant=0 one cycle later.
3. Round-robin fairness: N=4, ROUND_ROBIN=1, req=4'b1111 constant, each holder drops its req for one cycle after 1 granted cycle -> grant sequence 0,1,2,3,0,… Also check ptr wraps from 3 to 0.
4. Timeout: N=4, MAX_HOLD=3, ROUND_ROBIN=1, req=4'b0011 held constant -> grant bit 0 for 3 cycles, then bit 1 for 3 cycles, alternating. Then req=4'b0001 only -> bit 0 is re-granted continuously with cnt restarting and grant_valid never dropping.
5. Reset mid-operation: while grant=4'b0100 is held, assert reset for 1 cycle -> grant=0 the next cycle. With req=4'b1100 after reset and RR mode -> first winner is bit 2, because ptr was reset to 0.
6. Random stress: N=8, both modes, 10k cycles of random req -> grant is always one-hot or zero, grant_idx matches grant, no requester waits more than 8·MAX_HOLD cycles in RR mode, and the grant only changes on release, timeout or from IDLE.
